// File: rtl/shift_mux_if.sv
// shift_mux_if: operand/result bundle for the registered barrel shifter.
// master drives the operand side and reads results; slave is the shifter.
// With SHIFT_ROTATE_EN defined the bundle also carries the rotate request.
interface shift_mux_if #(
    parameter int DATA_W = 32,
    parameter int SA_W   = 5
);
    logic              in_valid;
    logic [DATA_W-1:0] d;
    logic [SA_W-1:0]   sa;
    logic              right;
    logic              arith;
`ifdef SHIFT_ROTATE_EN
    logic              rotate;
`endif
    logic [DATA_W-1:0] sh;
    logic              carry;
    logic              out_valid;

`ifdef SHIFT_ROTATE_EN
    modport master (
        output in_valid, d, sa, right, arith, rotate,
        input  sh, carry, out_valid
    );

    modport slave (
        input  in_valid, d, sa, right, arith, rotate,
        output sh, carry, out_valid
    );
`else
    modport master (
        output in_valid, d, sa, right, arith,
        input  sh, carry, out_valid
    );

    modport slave (
        input  in_valid, d, sa, right, arith,
        output sh, carry, out_valid
    );
`endif
endinterface

// File: rtl/shift_mux.sv
// shift_mux: registered barrel shifter for the ALU datapath.
// Logical left, logical right and arithmetic right, plus the last bit shifted
// out as carry. One output register; result appears the edge in_valid is sampled.
// Optional feature: define SHIFT_ROTATE_EN to add rotate left/right.
//
// Left shifts reuse the right-shift network: the operand is bit-reversed,
// shifted right with zero fill, and reversed back. The carry index then becomes
// sa-1 of the (possibly reversed) operand for both directions.
// DATA_W must be a power of two >= 8 and SA_W must equal $clog2(DATA_W).
module shift_mux #(
    parameter int DATA_W = 32,
    parameter int SA_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    shift_mux_if.slave bus
);

    logic [DATA_W-1:0] w_rev_d;
    logic [DATA_W-1:0] w_op;
    logic [DATA_W-1:0] w_cur;
    logic [DATA_W-1:0] w_res;
    logic [SA_W-1:0]   w_carry_idx;
    logic              w_carry;
    logic              w_fill;
    logic              w_rot;

    logic [DATA_W-1:0] r_sh;
    logic              r_carry;
    logic              r_out_valid;

    function automatic logic [DATA_W-1:0] f_reverse(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

`ifdef SHIFT_ROTATE_EN
    assign w_rot = bus.rotate;
`else
    assign w_rot = 1'b0;
`endif

    // Operand orientation: right shifts use d as-is, left shifts use d reversed.
    always_comb begin
        w_rev_d = f_reverse(bus.d);
        w_op    = bus.right ? bus.d : w_rev_d;
    end

    // Sign fill only for arithmetic right shifts; rotates never fill.
    assign w_fill = bus.right & bus.arith & ~w_rot & bus.d[DATA_W-1];

    // Log-depth right-shift network: stage s moves by 2**s when sa[s] is set.
    always_comb begin
        w_cur = w_op;
        for (int s = 0; s < SA_W; s++) begin
            if (bus.sa[s]) begin
`ifdef SHIFT_ROTATE_EN
                if (w_rot) begin
                    w_cur = (w_cur >> (1 << s)) | (w_cur << (DATA_W - (1 << s)));
                end else begin
                    w_cur = (w_cur >> (1 << s)) |
                            (w_fill ? ~({DATA_W{1'b1}} >> (1 << s)) : {DATA_W{1'b0}});
                end
`else
                w_cur = (w_cur >> (1 << s)) |
                        (w_fill ? ~({DATA_W{1'b1}} >> (1 << s)) : {DATA_W{1'b0}});
`endif
            end
        end
    end

    // Undo the reversal for left operations.
    always_comb begin
        w_res = bus.right ? w_cur : f_reverse(w_cur);
    end

    // Carry is bit sa-1 of the oriented operand; sa=0 shifts nothing out.
    always_comb begin
        w_carry_idx = bus.sa - SA_W'(1);
        w_carry     = (bus.sa != '0) ? w_op[w_carry_idx] : 1'b0;
    end

    // Output register: captures only on in_valid, out_valid follows in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh        <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sh    <= w_res;
                r_carry <= w_carry;
            end
        end
    end

    assign bus.sh        = r_sh;
    assign bus.carry     = r_carry;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_shift_mux.sv
// tb_shift_mux: scoreboard bench for shift_mux; driver pushes expected results,
// monitor pops them whenever out_valid is seen and checks holds otherwise.
module tb_shift_mux;
    localparam int DATA_W = 32;
    localparam int SA_W   = 5;

    typedef struct {
        logic [DATA_W-1:0] sh;
        logic              c;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t q[$];
    logic [DATA_W-1:0] last_sh;
    logic              last_c;

    shift_mux_if #(.DATA_W(DATA_W), .SA_W(SA_W)) bus ();

    shift_mux #(.DATA_W(DATA_W), .SA_W(SA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [DATA_W-1:0] d, input int n,
                                   input logic right, input logic arith, input logic rot);
        exp_t e;
        if (n == 0) begin
            e.sh = d;
            e.c  = 1'b0;
        end else if (!right) begin
            e.sh = d << n;
            if (rot) e.sh = e.sh | (d >> (DATA_W - n));
            e.c  = d[DATA_W-n];
        end else begin
            if (rot)        e.sh = (d >> n) | (d << (DATA_W - n));
            else if (arith) e.sh = $unsigned($signed(d) >>> n);
            else            e.sh = d >> n;
            e.c  = d[n-1];
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [SA_W-1:0] sa,
                         input logic right, input logic arith, input logic rot);
        @(negedge clk);
        bus.in_valid = v;
        bus.d        = d;
        bus.sa       = sa;
        bus.right    = right;
        bus.arith    = arith;
`ifdef SHIFT_ROTATE_EN
        bus.rotate   = rot;
`endif
        if (v) q.push_back(model(d, int'(sa), right, arith, rot));
    endtask

    // Monitor: compare on out_valid, otherwise outputs must hold.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got out_valid=1 expected no pending result");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sh", bus.sh, e.sh);
                    check("carry", {31'b0, bus.carry}, {31'b0, e.c});
                    last_sh = e.sh;
                    last_c  = e.c;
                end
            end else begin
                check("hold_sh", bus.sh, last_sh);
                check("hold_carry", {31'b0, bus.carry}, {31'b0, last_c});
            end
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        last_sh      = '0;
        last_c       = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.d        = '0;
        bus.sa       = '0;
        bus.right    = 1'b0;
        bus.arith    = 1'b0;
`ifdef SHIFT_ROTATE_EN
        bus.rotate   = 1'b0;
`endif
        #3;
        check("reset_sh", bus.sh, '0);
        check("reset_carry", {31'b0, bus.carry}, 32'd0);
        check("reset_valid", {31'b0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, back-to-back.
        drive(1'b1, 32'hff0000ff, 5'd8, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h00000009, 5'd8, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h00000008, 5'd8, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 32'h80000001, 5'd4, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 32'h00000009, 5'd1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'hff0000ff, 5'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h80000000, 5'd31, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 32'h00000001, 5'd31, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h80000000, 5'd0, 1'b1, 1'b1, 1'b0);
`ifdef SHIFT_ROTATE_EN
        drive(1'b1, 32'hff0000ff, 5'd8, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h000000f1, 5'd4, 1'b1, 1'b1, 1'b1);
`endif
        // Idle cycles with garbage inputs: outputs must hold.
        drive(1'b0, 32'hdeadbeef, 5'd3, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'h12345678, 5'd7, 1'b0, 1'b0, 1'b0);

        // Reset pulse between edges with a result pending at the inputs.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.d        = 32'hcafef00d;
        bus.sa       = 5'd5;
        bus.right    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_sh", bus.sh, '0);
        check("midrst_carry", {31'b0, bus.carry}, 32'd0);
        check("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
        bus.in_valid = 1'b0;
        q.delete();
        last_sh = '0;
        last_c  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic rot;
`ifdef SHIFT_ROTATE_EN
            rot = 1'($urandom_range(0, 3) == 0);
`else
            rot = 1'b0;
`endif
            drive(1'($urandom_range(0, 3) != 0), $urandom(), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rot);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
